// File: rtl/rtttl_tone_gen.sv
// rtttl_tone_gen: square-wave tone generator fed by rtttl_sequencer.
//
// Turns a registered {octave, note} code into a 50 % duty square wave at the
// equal-tempered pitch. Pauses and invalid codes hold the pin low.
//
// Ports:
//   clk        system clock, all state on its rising edge
//   rstn       asynchronous active-low reset
//   octave     octave code, 0..7 valid, 8..15 pause
//   note       note code, 1..12 = C..B, 0 and 13..15 pause
//   audio_out  square-wave output
//   active     high while a tone is playing
//
// Configuration macro: RTTTL_TONE_SYNC_CHANGE_EN
//   defined   - code changes are applied only at half-period boundaries (no runts)
//   undefined - in PLAY a change of the registered code takes effect at once
module rtttl_tone_gen #(
    parameter int unsigned CLK_HZ = 1_000_000,
    parameter int unsigned CNT_W  = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] octave,
    input  logic [3:0] note,
    output logic       audio_out,
    output logic       active
);

    // Octave-7 half-period in clocks, rounded to nearest, from a frequency in mHz.
    function automatic longint unsigned h7_of(input longint unsigned f_mhz);
        return (64'(CLK_HZ) * 64'd1000 + f_mhz) / (64'd2 * f_mhz);
    endfunction

    localparam longint unsigned H7C64 = h7_of(64'd2093005);

    localparam logic [CNT_W-1:0] H7_C  = CNT_W'(H7C64);
    localparam logic [CNT_W-1:0] H7_CS = CNT_W'(h7_of(64'd2217461));
    localparam logic [CNT_W-1:0] H7_D  = CNT_W'(h7_of(64'd2349318));
    localparam logic [CNT_W-1:0] H7_DS = CNT_W'(h7_of(64'd2489016));
    localparam logic [CNT_W-1:0] H7_E  = CNT_W'(h7_of(64'd2637020));
    localparam logic [CNT_W-1:0] H7_F  = CNT_W'(h7_of(64'd2793826));
    localparam logic [CNT_W-1:0] H7_FS = CNT_W'(h7_of(64'd2959955));
    localparam logic [CNT_W-1:0] H7_G  = CNT_W'(h7_of(64'd3135963));
    localparam logic [CNT_W-1:0] H7_GS = CNT_W'(h7_of(64'd3322438));
    localparam logic [CNT_W-1:0] H7_A  = CNT_W'(h7_of(64'd3520000));
    localparam logic [CNT_W-1:0] H7_AS = CNT_W'(h7_of(64'd3729310));
    localparam logic [CNT_W-1:0] H7_B  = CNT_W'(h7_of(64'd3951066));

    // Octave-0 C is the longest half-period; everything else fits if it does.
    if ((H7C64 << 7) >= (64'd1 << CNT_W)) begin : g_cnt_w_too_small
        $error("CNT_W too narrow for the octave-0 C half-period");
    end

    typedef enum logic {StIdle, StPlay} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             audio_q, audio_d;
    logic [3:0]       oct_q, note_q;

    logic [CNT_W-1:0] h7;
    logic [CNT_W-1:0] half_per;
    logic             code_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            oct_q  <= 4'd0;
            note_q <= 4'd0;
        end else begin
            oct_q  <= octave;
            note_q <= note;
        end
    end

`ifndef RTTTL_TONE_SYNC_CHANGE_EN
    logic [7:0] code_prev_q;
    logic       code_changed;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            code_prev_q <= 8'd0;
        end else begin
            code_prev_q <= {oct_q, note_q};
        end
    end

    assign code_changed = ({oct_q, note_q} != code_prev_q);
`endif

    always_comb begin
        h7 = '0;
        case (note_q)
            4'd1:    h7 = H7_C;
            4'd2:    h7 = H7_CS;
            4'd3:    h7 = H7_D;
            4'd4:    h7 = H7_DS;
            4'd5:    h7 = H7_E;
            4'd6:    h7 = H7_F;
            4'd7:    h7 = H7_FS;
            4'd8:    h7 = H7_G;
            4'd9:    h7 = H7_GS;
            4'd10:   h7 = H7_A;
            4'd11:   h7 = H7_AS;
            4'd12:   h7 = H7_B;
            default: h7 = '0;
        endcase
    end

    assign code_valid = !oct_q[3] && (note_q != 4'd0) && (note_q <= 4'd12);
    // Lower octaves double the half-period per step below octave 7.
    assign half_per   = h7 << (3'd7 - oct_q[2:0]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        audio_d = audio_q;
        case (state_q)
            StIdle: begin
                cnt_d   = '0;
                audio_d = 1'b0;
                if (code_valid) begin
                    state_d = StPlay;
                    cnt_d   = half_per - CNT_W'(1);
                    audio_d = 1'b1;
                end
            end
            StPlay: begin
`ifndef RTTTL_TONE_SYNC_CHANGE_EN
                // Immediate-change build: a new code restarts the phase high.
                if (code_changed) begin
                    if (code_valid) begin
                        cnt_d   = half_per - CNT_W'(1);
                        audio_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        audio_d = 1'b0;
                    end
                end else
`endif
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (code_valid) begin
                    cnt_d   = half_per - CNT_W'(1);
                    audio_d = ~audio_q;
                end else begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    audio_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                audio_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            audio_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            audio_q <= audio_d;
        end
    end

    assign audio_out = audio_q;
    assign active    = (state_q == StPlay);

endmodule

// File: doc/rtttl_tone_gen.md
# rtttl_tone_gen

Square-wave tone generator directly downstream of `rtttl_sequencer`. It consumes the sequencer's `octave`/`note` codes and drives a 1-bit audio pin at the corresponding equal-tempered pitch. It applies pitch changes only at half-period boundaries, so the output never carries a runt pulse. It holds the pin low for pauses and invalid codes.

## Interface
- `CLK_HZ`, default 1_000_000: system clock frequency in Hz.
- `CNT_W`, default 16: half-period counter width. It must hold the octave-0 C half-period (elaboration error otherwise).
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rstn`  input  1  reset. One clock; reset is asynchronous and active-low.
- `octave`  input  4  octave code from the sequencer; 0..7 valid, 8..15 = pause.
- `note`  input  4  note code; 0 = pause, 1..12 = C, C#, D, D#, E, F, F#, G, G#, A, A#, B; 13..15 = pause.
- `audio_out`  output  1  square wave, 50 % duty.
- `active`  output  1  high while in the PLAY state.

## Operation
- **Input register:** `octave`/`note` are registered into `oct_q`/`note_q` every cycle. All decisions use the registered values.
- **Base table:** octave-7 half-periods are compiler-constant integers, computed with 64-bit constant arithmetic as `H7 = (CLK_HZ*1000 + f) / (2*f)`, where `f` is the octave-7 frequency in mHz:
  - C 2093005, C# 2217461, D 2349318, D# 2489016, E 2637020, F 2793826
  - F# 2959955, G 3135963, G# 3322438, A 3520000, A# 3729310, B 3951066
- **Octave scaling:** target half-period `H = H7 << (7 - oct_q)`.
- **State IDLE:**
  - `audio_out` = 0, `active` = 0, counter = 0.
  - When the registered code is a valid note, on the next edge: counter ← H-1, `audio_out` ← 1, state → PLAY.
- **State PLAY:**
  - If counter ≠ 0: decrement.
  - If counter = 0 (boundary), re-evaluate the registered code:
    - Valid note: counter ← H-1 using the current code, and `audio_out` toggles.
    - Pause/invalid: `audio_out` ← 0, counter ← 0, state → IDLE.
  - Each phase therefore lasts exactly H cycles.
- **Changes mid-phase:** a code change mid-phase does not alter the running phase. The new H applies from the next boundary.
- **Returning to pause:** a valid → pause transition ending a high phase drops the output at that boundary, i.e. one low edge, no extra toggle.
- **Reset (asserted any time):** `audio_out` = 0, `active` = 0, state = IDLE, counter = 0, `oct_q`/`note_q` = 0. Takes effect immediately and asynchronously.

## Timing
- **Start latency:** a valid code first presented before edge n is registered at edge n, and `audio_out` rises at edge n+1.
- **Period:** 2·H cycles. High and low phases are H each.
- **Boundary re-evaluation:** the code is re-evaluated only in the counter-zero cycle. A code that changes and reverts between boundaries has no effect.
- **Pause latency in PLAY:** ≤ H cycles, plus 1 for the input register.
- **Reset release:** reset released asynchronously. The first edge after release with a valid code registers it; the output rises one edge later.

## Configuration
- **Macro:** `RTTTL_TONE_SYNC_CHANGE_EN`.
- **Defined:** boundary-synchronous changes, exactly as described in Operation.
- **Undefined:** in PLAY, any cycle where `{oct_q, note_q}` differs from the previous cycle's value takes effect immediately:
  - Valid new code: counter ← new H-1 and `audio_out` ← 1.
  - Pause/invalid new code: `audio_out` ← 0 and state → IDLE.
  - Runt pulses are then permitted.
- **Unaffected by the macro:** IDLE behaviour and reset behaviour are identical in both builds.

## Test plan
All scenarios use `CLK_HZ` = 1_000_000.
- **Reset:** hold `rstn` = 0 for 10 cycles with octave 7 / note 10 applied -> `audio_out` = 0 and `active` = 0 throughout; after release, `audio_out` rises on the 2nd edge.
- **A7:** octave 7, note 10 -> high 142 cycles, low 142, period 284, `active` = 1.
- **C4:** octave 4, note 1 -> H = 239<<3 = 1912; period 3824 cycles.
- **Change mid-phase:** switch A7 → C7, 50 cycles into a high phase.
  - Macro defined: high phase still 142 cycles, then low 239.
  - Macro undefined: `audio_out` stays 1 and the phase restarts for 239 cycles from the change plus 1 cycle.
- **Pause:** note 0 mid-high phase -> `audio_out` falls at the boundary and `active` = 0 the same edge. Octave 8 with note 5 -> never leaves IDLE.
- **Reset mid-play:** assert `rstn` = 0 mid-high phase -> `audio_out` = 0 with no clock edge; on release with A7 still applied, clean restart with a 142-cycle high phase.
